// File: rtl/lif_spike_monitor_if.sv
// Result/control bundle between the LIF spike monitor and its host/readout logic.
interface lif_spike_monitor_if;
  logic       en;
  logic       spike_in;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] rate_count;
  logic [7:0] isi_last;
  logic [7:0] isi_min;
  logic       burst;
  logic       overrun;

  // Host side: drives enable, spike stream and ready; observes the result register.
  modport master (
    output en, spike_in, out_ready,
    input  out_valid, rate_count, isi_last, isi_min, burst, overrun
  );

  // Monitor side.
  modport slave (
    input  en, spike_in, out_ready,
    output out_valid, rate_count, isi_last, isi_min, burst, overrun
  );
endinterface

// File: rtl/lif_spike_monitor.sv
// Windowed spike statistics for one LIF neuron: event count, last/min ISI and burst flag,
// reported per observation window through a valid/ready holding register.
module lif_spike_monitor #(
  parameter int unsigned WINDOW    = 256,
  parameter int unsigned BURST_ISI = 4
) (
  input logic                clk,
  input logic                rst,
  lif_spike_monitor_if.slave mon
);

  localparam logic [7:0] WinLast = 8'(WINDOW - 1);
  localparam logic [7:0] Sat     = 8'hFF;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e     r_state, w_state_d;
  logic [7:0] r_win;
  logic       r_spike_q;
  logic [7:0] r_isi_cnt;
  logic       r_have_prev;
  logic [7:0] r_isi_last;
  logic [7:0] r_cnt;
  logic [7:0] r_min;
  logic       r_burst;

  logic       r_out_valid;
  logic [7:0] r_out_rate;
  logic [7:0] r_out_last;
  logic [7:0] r_out_min;
  logic       r_out_burst;
  logic       r_overrun;

  logic [7:0] w_win_cur;
  logic       w_event;
  logic       w_meas;
  logic       w_closing;
  logic [7:0] w_cnt_nx;
  logic [7:0] w_last_nx;
  logic [7:0] w_min_nx;
  logic       w_burst_nx;
  logic       w_hs;
  logic       w_load;
  logic       w_drop;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_d;
  end

  // Next state: enable alone decides; any low cycle abandons the window.
  always_comb begin
    w_state_d = StIdle;
    if (mon.en) w_state_d = StRun;
  end

  // Event detection, ISI measurement and window-close decode, all for the current cycle.
  always_comb begin
    // The first RUN cycle is always window cycle 0, whatever the counter holds.
    w_win_cur  = (r_state == StIdle) ? 8'd0 : r_win;
    w_event    = mon.en & mon.spike_in & ~r_spike_q;
    w_meas     = w_event & r_have_prev;
    w_closing  = mon.en & (w_win_cur == WinLast);
    w_cnt_nx   = (w_event && r_cnt != Sat) ? r_cnt + 8'd1 : r_cnt;
    w_last_nx  = w_meas ? r_isi_cnt : r_isi_last;
    w_min_nx   = (w_meas && r_isi_cnt < r_min) ? r_isi_cnt : r_min;
    w_burst_nx = r_burst | (w_meas && (32'(r_isi_cnt) <= BURST_ISI));
    w_hs       = r_out_valid & mon.out_ready;
    // A result may load into an empty register or one being drained this very cycle.
    w_load     = w_closing & (~r_out_valid | mon.out_ready);
    w_drop     = w_closing & ~w_load;
  end

  // Window counter, ISI counter and per-window accumulators.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win       <= '0;
      r_spike_q   <= 1'b0;
      r_isi_cnt   <= '0;
      r_have_prev <= 1'b0;
      r_isi_last  <= '0;
      r_cnt       <= '0;
      r_min       <= Sat;
      r_burst     <= 1'b0;
    end else if (!mon.en) begin
      r_win       <= '0;
      r_spike_q   <= 1'b0;
      r_isi_cnt   <= '0;
      r_have_prev <= 1'b0;
      r_isi_last  <= '0;
      r_cnt       <= '0;
      r_min       <= Sat;
      r_burst     <= 1'b0;
    end else begin
      r_spike_q  <= mon.spike_in;
      r_isi_last <= w_last_nx;
      if (w_event)               r_isi_cnt <= 8'd1;
      else if (r_isi_cnt != Sat) r_isi_cnt <= r_isi_cnt + 8'd1;
      if (w_event) r_have_prev <= 1'b1;
      if (w_closing) begin
        r_win   <= '0;
        r_cnt   <= '0;
        r_min   <= Sat;
        r_burst <= 1'b0;
      end else begin
        r_win   <= w_win_cur + 8'd1;
        r_cnt   <= w_cnt_nx;
        r_min   <= w_min_nx;
        r_burst <= w_burst_nx;
      end
    end
  end

  // Result holding register with valid/ready handshake and sticky overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_rate  <= '0;
      r_out_last  <= '0;
      r_out_min   <= Sat;
      r_out_burst <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_rate  <= w_cnt_nx;
        r_out_last  <= w_last_nx;
        r_out_min   <= w_min_nx;
        r_out_burst <= w_burst_nx;
      end else if (w_hs) begin
        r_out_valid <= 1'b0;
      end
      if (w_drop) r_overrun <= 1'b1;
    end
  end

  // Output drive.
  always_comb begin
    mon.out_valid  = r_out_valid;
    mon.rate_count = r_out_rate;
    mon.isi_last   = r_out_last;
    mon.isi_min    = r_out_min;
    mon.burst      = r_out_burst;
    mon.overrun    = r_overrun;
  end

endmodule

// File: doc/lif_spike_monitor.md
# lif_spike_monitor

Downstream stage of the LIF neuron core. Consumes the neuron's spike bit, detects spike events, and per fixed observation window reports spike count, last inter-spike interval (ISI), minimum ISI and a burst flag. Results are presented through a valid/ready holding register to the readout/host logic. The block lets the host read a rate-coded view of neuron activity instead of sampling raw spike pulses.

## Interface

- WINDOW, 256: observation window length in enabled cycles, 2..256.
- BURST_ISI, 4: ISI at or below this value (in cycles) marks the window as bursting.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  monitor enable; low = idle, window discarded.
- spike_in  in  1  spike bit from the LIF neuron output; may stay high for more than one cycle.
- out_ready  in  1  consumer accepts the result when high together with out_valid.
- out_valid  out  1  result register holds an unaccepted window result.
- rate_count  out  8  spike events in the reported window, saturating at 255.
- isi_last  out  8  most recent ISI measured up to the window end; 0 = none measured since reset/enable.
- isi_min  out  8  smallest ISI measured inside the reported window; 255 if none.
- burst  out  1  some ISI inside the reported window was <= BURST_ISI.
- overrun  out  1  sticky: a window result was dropped because the register was full.

## Operation

- Event: event = spike_in & ~spike_q, where spike_q is spike_in registered on enabled cycles. A multi-cycle high pulse is one event.
- States: IDLE, RUN.
  - IDLE: entered on reset or when en is low. Window counter, accumulators, spike_q, ISI counter and have_prev are cleared. The output register and overrun are held.
  - IDLE -> RUN: on the first cycle with en high. That cycle is window cycle 0 and its event is counted.
  - RUN -> IDLE: on any cycle with en low. The partial window is discarded and no result is produced.
- Window counter: counts 0..WINDOW-1, wraps to 0. The cycle with count WINDOW-1 is the closing cycle, and an event on it belongs to the closing window.
- Count accumulator: +1 per event, saturating at 255. Cleared after the closing cycle.
- ISI counter (8 bit):
  - On an event it loads 1.
  - Otherwise it increments, saturating at 255.
  - On an event with have_prev = 1, the measured ISI equals the ISI counter value before the load; events at cycles t and t+5 give ISI 5. Saturated intervals report 255.
  - have_prev sets on the first event. The ISI counter runs across window boundaries.
- Per-window trackers: min ISI (reset to 255 each window) and burst (reset to 0 each window), updated on each measured ISI, including one on the closing cycle.
- Result transfer, after the closing cycle:
  - If out_valid = 0, or the handshake (out_valid & out_ready) fires in the closing cycle: load rate_count, isi_last, isi_min and burst, and set out_valid = 1.
  - Otherwise: drop the result, set overrun = 1, and leave the register unchanged.
- Handshake: the output register is held stable while out_valid & ~out_ready. out_valid clears the cycle after the handshake unless a new result loads in that same cycle.
- Arithmetic: all counters are unsigned 8 bit and saturating; nothing wraps except the window counter.

## Timing

- Reset values: out_valid 0, rate_count 0, isi_last 0, isi_min 255, burst 0, overrun 0; state IDLE.
- Event detection is 0-latency relative to the spike_in rise, which is sampled in that cycle.
- Result latency: outputs update and out_valid rises on the clock edge ending the closing cycle, so they are visible the cycle after the closing cycle.
- Window period: exactly WINDOW enabled cycles. Back-to-back windows have no gap.
- Reset asserted mid-window or mid-handshake: all state returns to reset values immediately, and the pending result is lost.
- Reset deasserted: the first RUN cycle is the first edge after release with en high.
- Simultaneous handshake and new result: new result loaded, out_valid stays 1, overrun unchanged.

## Test plan

- WINDOW=16, spike_in pulses (1 cycle) at window cycles 2, 7, 15 with out_ready=1 -> result: rate_count 3, isi_last 8, isi_min 5, burst 0, out_valid high 1 cycle.
- spike_in held high 10 cycles starting at cycle 0 -> rate_count 1, isi_last 0 (no prior event), isi_min 255.
- Events 3 cycles apart, BURST_ISI=4 -> burst 1, isi_min 3. Events 20 apart across windows -> isi_last 20 in the later window.
- out_ready=0 for two full windows -> first result held unchanged, overrun=1 after second closing cycle. Handshake in a closing cycle -> new result loads, overrun stays 0.
- Continuous toggling spike_in (event every 2 cycles), WINDOW=256 -> rate_count 128. Spike_in pattern producing >255 events is impossible at WINDOW=256, so force via hold test: saturation check with ISI gap 300 cycles -> isi_last 255.
- Drop en at window cycle 9, re-raise -> no result emitted, new window starts at cycle 0. Assert rst mid-window with out_valid=1 -> all outputs at reset values next cycle.
